demux_channel_deserializer: RTL

//  Downstream consumer of the 1:8 demux stage. On each strobe it samples the demux output bit y[sel]
//  and shifts it into a per-channel shift register. Each of the 8 channels assembles WORD_W-bit words.

---
 rtl/demux_pkg.sv | 12 +
 rtl/rr_arbiter_8.sv | 27 ++
 rtl/demux_channel_deserializer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared types for the demux channel deserializer: channel index width and output FSM states.
package demux_pkg;
  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] ch_idx_t;

  typedef enum logic {
    S_IDLE,
    S_PRESENT
  } out_state_e;
endpackage

// File: rtl/rr_arbiter_8.sv
// Combinational round-robin pick: first set request bit searching upward from ptr, modulo 8.
module rr_arbiter_8
  import demux_pkg::*;
(
  input  logic [NCH-1:0] req,
  input  ch_idx_t        ptr,
  output ch_idx_t        gnt_idx,
  output logic           any
);

  ch_idx_t idx;

  // Walk offsets from farthest to nearest so the nearest requester is the last one written.
  always_comb begin
    gnt_idx = ptr;
    any     = 1'b0;
    idx     = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = ptr + ch_idx_t'(i);
      if (req[idx]) begin
        gnt_idx = idx;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_channel_deserializer.sv
// Per-channel serial-to-parallel assembly of demux output bits, with hold registers drained
// round-robin over a valid/ready port and sticky per-channel overflow flags.
module demux_channel_deserializer
  import demux_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              strobe,
  input  ch_idx_t           sel,
  input  logic [NCH-1:0]    y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output ch_idx_t           out_ch,
  output logic [NCH-1:0]    ovf,
  input  logic              clr_ovf
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  logic [WORD_W-1:0] sr_q   [NCH];
  logic [WORD_W-1:0] sr_d   [NCH];
  logic [CNT_W-1:0]  cnt_q  [NCH];
  logic [CNT_W-1:0]  cnt_d  [NCH];
  logic [WORD_W-1:0] hold_q [NCH];
  logic [WORD_W-1:0] hold_d [NCH];
  logic [NCH-1:0]    hold_valid_q, hold_valid_d;
  logic [NCH-1:0]    ovf_q, ovf_d;
  out_state_e        state_q, state_d;
  ch_idx_t           cur_q, cur_d;
  ch_idx_t           rr_ptr_q, rr_ptr_d;

  logic              drain;
  logic [WORD_W-1:0] word;
  ch_idx_t           gnt_idx;
  logic              gnt_any;

  rr_arbiter_8 u_arb (
    .req     (hold_valid_q),
    .ptr     (rr_ptr_q),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  assign drain = (state_q == S_PRESENT) && out_ready;
  assign word  = {sr_q[sel][WORD_W-2:0], y[sel]};

  // Capture path. A channel being drained this edge may be reloaded; otherwise a full
  // hold register makes the new word overflow, so the presented word never changes.
  always_comb begin
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    ovf_d        = clr_ovf ? '0 : ovf_q;
    if (drain) begin
      hold_valid_d[cur_q] = 1'b0;
    end
    if (strobe) begin
      sr_d[sel] = word;
      if (cnt_q[sel] == CNT_LAST) begin
        cnt_d[sel] = '0;
        if (!hold_valid_q[sel] || (drain && (cur_q == sel))) begin
          hold_d[sel]       = word;
          hold_valid_d[sel] = 1'b1;
        end else begin
          ovf_d[sel] = 1'b1;
        end
      end else begin
        cnt_d[sel] = cnt_q[sel] + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          cur_d   = gnt_idx;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (out_ready) begin
          rr_ptr_d = cur_q + 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        sr_q[i]   <= '0;
        cnt_q[i]  <= '0;
        hold_q[i] <= '0;
      end
      hold_valid_q <= '0;
      ovf_q        <= '0;
      state_q      <= S_IDLE;
      cur_q        <= '0;
      rr_ptr_q     <= '0;
    end else begin
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      ovf_q        <= ovf_d;
      state_q      <= state_d;
      cur_q        <= cur_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign out_valid = (state_q == S_PRESENT);
  assign out_data  = out_valid ? hold_q[cur_q] : '0;
  assign out_ch    = cur_q;
  assign ovf       = ovf_q;

endmodule
